// File: rtl/pipe_stage_chain.sv
// Elastic register chain carrying a control and a data bundle through STAGES slots,
// with valid/ready backpressure and selective flush of the younger slots.
module pipe_stage_chain #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 16,
   parameter int STAGES = 3,
   parameter int CNT_W  = $clog2(STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic [CNT_W-1:0]  flush_stage,
   output logic [STAGES-1:0] stage_valid,
   output logic [CNT_W-1:0]  occupancy
);

   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] valid_d;
   logic [STAGES-1:0] ready;
   logic [CTRL_W-1:0] ctrl_q [STAGES];
   logic [CTRL_W-1:0] ctrl_d [STAGES];
   logic [DATA_W-1:0] data_q [STAGES];
   logic [DATA_W-1:0] data_d [STAGES];
   logic [CNT_W-1:0]  occ_q;
   logic [CNT_W-1:0]  occ_d;

   logic [STAGES-1:0] src_v;
   logic [CTRL_W-1:0] src_c [STAGES];
   logic [DATA_W-1:0] src_d [STAGES];
   logic              ready_acc;
   logic              load_v;
   int                flush_lim;

   // A slot is ready when it or any older slot is empty, or the consumer takes the output.
   always_comb begin
      ready_acc = out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         ready_acc = ready_acc | ~valid_q[k];
         ready[k]  = ready_acc;
      end
   end

   assign in_ready  = ready[0] & ~flush & rst_n;
   assign flush_lim = (int'(flush_stage) > STAGES) ? STAGES : int'(flush_stage);

   always_comb begin
      src_v[0] = in_valid & in_ready;
      src_c[0] = in_ctrl;
      src_d[0] = in_data;
      for (int k = 1; k < STAGES; k++) begin
         src_v[k] = valid_q[k-1];
         src_c[k] = ctrl_q[k-1];
         src_d[k] = data_q[k-1];
      end
   end

   // Killed slots drop valid/ctrl; the slot just above the kill boundary sees an empty source.
   always_comb begin
      occ_d  = '0;
      load_v = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         valid_d[k] = valid_q[k];
         ctrl_d[k]  = ctrl_q[k];
         data_d[k]  = data_q[k];
         load_v     = src_v[k] & ~(flush && (k == flush_lim));
         if (flush && (k < flush_lim)) begin
            valid_d[k] = 1'b0;
            ctrl_d[k]  = '0;
         end else if (ready[k]) begin
            valid_d[k] = load_v;
            ctrl_d[k]  = load_v ? src_c[k] : '0;
            if (load_v) begin
               data_d[k] = src_d[k];
            end
         end
         occ_d = occ_d + CNT_W'(valid_d[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
         occ_q   <= '0;
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= '0;
            data_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         for (int k = 0; k < STAGES; k++) begin
            ctrl_q[k] <= ctrl_d[k];
            data_q[k] <= data_d[k];
         end
      end
   end

   assign out_valid   = valid_q[STAGES-1];
   assign out_ctrl    = ctrl_q[STAGES-1];
   assign out_data    = data_q[STAGES-1];
   assign stage_valid = valid_q;
   assign occupancy   = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (3 slots): streaming, backpressure, flushes, reset.
// Entries are queued when driven and compared against the output slot while presented.
module tb_pipe_stage_chain;

   localparam int DATA_W = 128;
   localparam int CTRL_W = 16;
   localparam int STAGES = 3;
   localparam int CNT_W  = $clog2(STAGES + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [CTRL_W-1:0] out_ctrl;
   logic [DATA_W-1:0] out_data;
   logic              flush;
   logic [CNT_W-1:0]  flush_stage;
   logic [STAGES-1:0] stage_valid;
   logic [CNT_W-1:0]  occupancy;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t sb_q[$];
   entry_t dropped;
   int     checks = 0;
   int     errors = 0;
   int     stream_occ [7] = '{1, 2, 3, 3, 2, 1, 0};

   pipe_stage_chain #(
      .DATA_W(DATA_W),
      .CTRL_W(CTRL_W),
      .STAGES(STAGES)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ctrl    (in_ctrl),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_ctrl   (out_ctrl),
      .out_data   (out_data),
      .flush      (flush),
      .flush_stage(flush_stage),
      .stage_valid(stage_valid),
      .occupancy  (occupancy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
         $error("[TB] check %s did not match", tag);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                                input logic [DATA_W-1:0] d, input logic ordy,
                                input logic fl, input logic [CNT_W-1:0] fs, input logic rn);
      in_valid    = v;
      in_ctrl     = c;
      in_data     = d;
      out_ready   = ordy;
      flush       = fl;
      flush_stage = fs;
      rst_n       = rn;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pushEntry(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
      entry_t e;
      e.ctrl = c;
      e.data = d;
      sb_q.push_back(e);
   endtask

   task automatic checkFront(input string tag);
      checkOutput({tag, "_valid"}, DATA_W'(out_valid), DATA_W'(1));
      checkOutput({tag, "_sb_nonempty"}, DATA_W'(sb_q.size() != 0), DATA_W'(1));
      if (sb_q.size() != 0) begin
         checkOutput({tag, "_ctrl"}, DATA_W'(out_ctrl), DATA_W'(sb_q[0].ctrl));
         checkOutput({tag, "_data"}, out_data, sb_q[0].data);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset and idle
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      checkOutput("rst_in_ready", DATA_W'(in_ready), DATA_W'(0));
      tick();
      tick();
      checkOutput("rst_out_valid", DATA_W'(out_valid), DATA_W'(0));
      checkOutput("rst_out_ctrl", DATA_W'(out_ctrl), DATA_W'(0));
      checkOutput("rst_out_data", out_data, DATA_W'(0));
      checkOutput("rst_stage_valid", DATA_W'(stage_valid), DATA_W'(0));
      checkOutput("rst_occupancy", DATA_W'(occupancy), DATA_W'(0));
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("idle_in_ready", DATA_W'(in_ready), DATA_W'(1));
      tick();
      checkOutput("idle_occupancy", DATA_W'(occupancy), DATA_W'(0));

      // Streaming with continuous out_ready
      for (int c = 0; c < 7; c++) begin
         if (c < 4) begin
            applyStimulus(1'b1, CTRL_W'(c + 1), DATA_W'('hA0 + c), 1'b1, 1'b0, '0, 1'b1);
            checkOutput("stream_in_ready", DATA_W'(in_ready), DATA_W'(1));
            pushEntry(CTRL_W'(c + 1), DATA_W'('hA0 + c));
         end else begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
         end
         tick();
         checkOutput("stream_occupancy", DATA_W'(occupancy), DATA_W'(stream_occ[c]));
         if (c >= 2 && c <= 5) begin
            checkFront("stream_out");
            dropped = sb_q.pop_front();
         end else begin
            checkOutput("stream_idle_valid", DATA_W'(out_valid), DATA_W'(0));
            checkOutput("stream_idle_ctrl", DATA_W'(out_ctrl), DATA_W'(0));
         end
      end

      // Backpressure
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, CTRL_W'(5 + i), DATA_W'('hB0 + i), 1'b0, 1'b0, '0, 1'b1);
         checkOutput("fill_in_ready", DATA_W'(in_ready), DATA_W'(1));
         pushEntry(CTRL_W'(5 + i), DATA_W'('hB0 + i));
         tick();
      end
      applyStimulus(1'b1, CTRL_W'(8), DATA_W'('hB3), 1'b0, 1'b0, '0, 1'b1);
      checkOutput("bp_in_ready", DATA_W'(in_ready), DATA_W'(0));
      checkOutput("bp_occupancy", DATA_W'(occupancy), DATA_W'(3));
      tick();
      checkFront("bp_hold");
      checkOutput("bp_hold_occupancy", DATA_W'(occupancy), DATA_W'(3));
      checkOutput("bp_hold_stage_valid", DATA_W'(stage_valid), DATA_W'(3'b111));
      applyStimulus(1'b1, CTRL_W'(8), DATA_W'('hB3), 1'b1, 1'b0, '0, 1'b1);
      checkOutput("passthru_in_ready", DATA_W'(in_ready), DATA_W'(1));
      checkFront("bp_release");
      dropped = sb_q.pop_front();
      pushEntry(CTRL_W'(8), DATA_W'('hB3));
      tick();
      checkOutput("bp_after_occupancy", DATA_W'(occupancy), DATA_W'(3));
      checkFront("bp_after");

      // Partial flush of slots 0 and 1 while the output is stalled
      applyStimulus(1'b1, CTRL_W'('hEE), DATA_W'('hEE), 1'b0, 1'b1, CNT_W'(2), 1'b1);
      checkOutput("pflush_in_ready", DATA_W'(in_ready), DATA_W'(0));
      tick();
      dropped = sb_q.pop_back();
      dropped = sb_q.pop_back();
      checkOutput("pflush_stage_valid", DATA_W'(stage_valid), DATA_W'(3'b100));
      checkOutput("pflush_occupancy", DATA_W'(occupancy), DATA_W'(1));
      checkFront("pflush_out");
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
      dropped = sb_q.pop_front();
      tick();
      checkOutput("pflush_drain_valid", DATA_W'(out_valid), DATA_W'(0));
      checkOutput("pflush_drain_ctrl", DATA_W'(out_ctrl), DATA_W'(0));
      checkOutput("pflush_drain_occupancy", DATA_W'(occupancy), DATA_W'(0));

      // Flush with flush_stage=0 only blocks the input
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, CTRL_W'(9 + i), DATA_W'('hC0 + i), 1'b0, 1'b0, '0, 1'b1);
         checkOutput("fill2_in_ready", DATA_W'(in_ready), DATA_W'(1));
         pushEntry(CTRL_W'(9 + i), DATA_W'('hC0 + i));
         tick();
      end
      applyStimulus(1'b1, CTRL_W'('h55), DATA_W'('h55), 1'b0, 1'b1, CNT_W'(0), 1'b1);
      checkOutput("f0_in_ready", DATA_W'(in_ready), DATA_W'(0));
      tick();
      checkOutput("f0_stage_valid", DATA_W'(stage_valid), DATA_W'(3'b111));
      checkOutput("f0_occupancy", DATA_W'(occupancy), DATA_W'(3));
      checkFront("f0_out");

      // Flush slot 0 while output drains: slot 1 becomes a bubble, killed entry never advances
      applyStimulus(1'b1, CTRL_W'('h55), DATA_W'('h55), 1'b1, 1'b1, CNT_W'(1), 1'b1);
      checkOutput("f1_in_ready", DATA_W'(in_ready), DATA_W'(0));
      dropped = sb_q.pop_front();
      tick();
      dropped = sb_q.pop_back();
      checkOutput("f1_stage_valid", DATA_W'(stage_valid), DATA_W'(3'b100));
      checkOutput("f1_occupancy", DATA_W'(occupancy), DATA_W'(1));
      checkFront("f1_out");

      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, CTRL_W'(12 + i), DATA_W'('hC3 + i), 1'b0, 1'b0, '0, 1'b1);
         checkOutput("refill_in_ready", DATA_W'(in_ready), DATA_W'(1));
         pushEntry(CTRL_W'(12 + i), DATA_W'('hC3 + i));
         tick();
      end
      checkOutput("refill_stage_valid", DATA_W'(stage_valid), DATA_W'(3'b111));
      checkOutput("refill_occupancy", DATA_W'(occupancy), DATA_W'(3));
      checkFront("refill_out");

      // Full flush while the output entry is consumed
      applyStimulus(1'b1, CTRL_W'('h77), DATA_W'('h77), 1'b1, 1'b1, CNT_W'(STAGES), 1'b1);
      checkOutput("ffull_in_ready", DATA_W'(in_ready), DATA_W'(0));
      checkFront("ffull_out");
      tick();
      sb_q.delete();
      checkOutput("ffull_stage_valid", DATA_W'(stage_valid), DATA_W'(0));
      checkOutput("ffull_occupancy", DATA_W'(occupancy), DATA_W'(0));
      checkOutput("ffull_out_valid", DATA_W'(out_valid), DATA_W'(0));
      checkOutput("ffull_out_ctrl", DATA_W'(out_ctrl), DATA_W'(0));

      // Reset mid-stream overrides input, flush and output transfer
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, CTRL_W'(14 + i), DATA_W'('hD0 + i), 1'b0, 1'b0, '0, 1'b1);
         checkOutput("fill3_in_ready", DATA_W'(in_ready), DATA_W'(1));
         pushEntry(CTRL_W'(14 + i), DATA_W'('hD0 + i));
         tick();
      end
      checkOutput("fill3_stage_valid", DATA_W'(stage_valid), DATA_W'(3'b011));
      checkOutput("fill3_occupancy", DATA_W'(occupancy), DATA_W'(2));
      applyStimulus(1'b1, CTRL_W'('h99), DATA_W'('h99), 1'b1, 1'b1, CNT_W'(1), 1'b0);
      checkOutput("midrst_in_ready", DATA_W'(in_ready), DATA_W'(0));
      tick();
      sb_q.delete();
      checkOutput("midrst_out_valid", DATA_W'(out_valid), DATA_W'(0));
      checkOutput("midrst_out_ctrl", DATA_W'(out_ctrl), DATA_W'(0));
      checkOutput("midrst_out_data", out_data, DATA_W'(0));
      checkOutput("midrst_stage_valid", DATA_W'(stage_valid), DATA_W'(0));
      checkOutput("midrst_occupancy", DATA_W'(occupancy), DATA_W'(0));
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      checkOutput("post_rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
      tick();
      checkOutput("post_rst_occupancy", DATA_W'(occupancy), DATA_W'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
